// File: rtl/sparc_exu_addsub_pkg.sv
// rtl/sparc_exu_addsub_pkg.sv - shared flag struct and default sizes for the pipelined add/sub unit
package sparc_exu_addsub_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SPLIT = 32;
   localparam int DEF_TAG_W = 6;

   // Per-segment condition flags reported to the ECL alongside each sum
   typedef struct packed {
      logic cout_hi;
      logic cout_lo;
      logic ovf_hi;
      logic ovf_lo;
      logic zero_hi;
      logic zero_lo;
   } addsub_flags_t;

endpackage

// File: rtl/sparc_exu_addsub_seg.sv
// rtl/sparc_exu_addsub_seg.sv - combinational N-bit adder segment with carry and signed overflow
module sparc_exu_addsub_seg #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   // Full add; the extra top bit is the carry out of the segment msb
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

   // Signed overflow: like-signed operands producing a result of the other sign
   assign ovf = (a[N-1] == b[N-1]) & (sum[N-1] != a[N-1]);

endmodule

// File: rtl/sparc_exu_aluaddsub_pipe.sv
// rtl/sparc_exu_aluaddsub_pipe.sv - two-stage split add/sub with valid/ready, flush and ECL flags (option EXU_ADDSUB_SPR_EN)
module sparc_exu_aluaddsub_pipe
   import sparc_exu_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SPLIT = DEF_SPLIT,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             arst_l,
   input  logic             flush,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_rs1,
   input  logic [WIDTH-1:0] in_rs2,
   input  logic             in_invert,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_sum,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_cout_hi_l,
   output logic             out_cout_lo,
   output logic             out_ovf_hi,
   output logic             out_ovf_lo,
   output logic             out_zero_hi,
   output logic             out_zero_lo,
   output logic [1:0]       out_in2_msb
`ifdef EXU_ADDSUB_SPR_EN
   ,
   output logic             out_spr_zero
`endif
);

   localparam int HI_W = WIDTH - SPLIT;

   logic             s1_vld;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;
   logic [WIDTH-1:0] b_x;

   logic [SPLIT-1:0] lo_sum;
   logic             lo_cout;
   logic             lo_ovf;

   logic [HI_W-1:0]  s1_a_hi;
   logic [HI_W-1:0]  s1_b_hi;
   logic [SPLIT-1:0] s1_sum_lo;
   logic             s1_c_lo;
   logic             s1_ovf_lo;
   logic             s1_b_lo_msb;
   logic [TAG_W-1:0] s1_tag;

   logic [HI_W-1:0]  hi_sum;
   logic             hi_cout;
   logic             hi_ovf;

   addsub_flags_t    flags_d;
   addsub_flags_t    flags_q;

   // The output register is stage 2, so out_vld doubles as the stage-2 valid
   assign s2_adv = ~out_vld | out_rdy;
   assign s1_adv = s1_vld & s2_adv;
   assign in_rdy = ~flush & (~s1_vld | s2_adv);
   assign accept = in_vld & in_rdy;

   assign b_x = in_rs2 ^ {WIDTH{in_invert}};

   sparc_exu_addsub_seg #(.N(SPLIT)) u_seg_lo (
      .a   (in_rs1[SPLIT-1:0]),
      .b   (b_x[SPLIT-1:0]),
      .cin (in_cin),
      .sum (lo_sum),
      .cout(lo_cout),
      .ovf (lo_ovf)
   );

   sparc_exu_addsub_seg #(.N(HI_W)) u_seg_hi (
      .a   (s1_a_hi),
      .b   (s1_b_hi),
      .cin (s1_c_lo),
      .sum (hi_sum),
      .cout(hi_cout),
      .ovf (hi_ovf)
   );

   // Stage-1 occupancy: flush wins, then a new accept, then hand-off to stage 2
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         s1_vld <= 1'b0;
      end else if (flush) begin
         s1_vld <= 1'b0;
      end else if (accept) begin
         s1_vld <= 1'b1;
      end else if (s1_adv) begin
         s1_vld <= 1'b0;
      end
   end

   // Stage-1 payload: low half result plus the high operand halves for stage 2
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a_hi     <= in_rs1[WIDTH-1:SPLIT];
         s1_b_hi     <= b_x[WIDTH-1:SPLIT];
         s1_sum_lo   <= lo_sum;
         s1_c_lo     <= lo_cout;
         s1_ovf_lo   <= lo_ovf;
         s1_b_lo_msb <= b_x[SPLIT-1];
         s1_tag      <= in_tag;
      end
   end

   // Flags for the op leaving stage 1
   always_comb begin
      flags_d         = '0;
      flags_d.cout_hi = hi_cout;
      flags_d.cout_lo = s1_c_lo;
      flags_d.ovf_hi  = hi_ovf;
      flags_d.ovf_lo  = s1_ovf_lo;
      flags_d.zero_lo = ~|s1_sum_lo;
      flags_d.zero_hi = ~|s1_sum_lo & ~|hi_sum;
   end

   // Stage 2 / output registers: loaded on advance, held while the consumer stalls
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         out_vld     <= 1'b0;
         out_sum     <= '0;
         out_tag     <= '0;
         flags_q     <= '0;
         out_in2_msb <= 2'b00;
      end else begin
         if (flush) begin
            out_vld <= 1'b0;
         end else if (s2_adv) begin
            out_vld <= s1_vld;
         end
         if (s1_adv && !flush) begin
            out_sum     <= {hi_sum, s1_sum_lo};
            out_tag     <= s1_tag;
            flags_q     <= flags_d;
            out_in2_msb <= {s1_b_hi[HI_W-1], s1_b_lo_msb};
         end
      end
   end

   assign out_cout_hi_l = ~flags_q.cout_hi;
   assign out_cout_lo   = flags_q.cout_lo;
   assign out_ovf_hi    = flags_q.ovf_hi;
   assign out_ovf_lo    = flags_q.ovf_lo;
   assign out_zero_hi   = flags_q.zero_hi;
   assign out_zero_lo   = flags_q.zero_lo;

`ifdef EXU_ADDSUB_SPR_EN
   // Zero predict without the carry chain: a zero sum means every carry into bit i
   // equals a|b of bit i-1, with cin as the carry into bit 0
   logic [WIDTH-2:0] a_or_b;
   logic             spr_d;
   logic             s1_spr;

   assign a_or_b = in_rs1[WIDTH-2:0] | b_x[WIDTH-2:0];
   assign spr_d  = ~|(in_rs1 ^ b_x ^ {a_or_b, in_cin});

   // Prediction travels beside the stage-1 payload
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_spr <= spr_d;
      end
   end

   // Prediction output register tracks the stage-2 load
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         out_spr_zero <= 1'b0;
      end else if (s1_adv && !flush) begin
         out_spr_zero <= s1_spr;
      end
   end
`endif

endmodule

// File: tb/tb_sparc_exu_aluaddsub_pipe.sv
// tb/tb_sparc_exu_aluaddsub_pipe.sv - randomized and directed self-checking bench for the add/sub pipe
module tb_sparc_exu_aluaddsub_pipe;

   logic        clk = 1'b0;
   logic        arst_l;
   logic        flush;
   logic        in_vld;
   logic        in_rdy;
   logic [63:0] in_rs1;
   logic [63:0] in_rs2;
   logic        in_invert;
   logic        in_cin;
   logic [5:0]  in_tag;
   logic        out_vld;
   logic        out_rdy;
   logic [63:0] out_sum;
   logic [5:0]  out_tag;
   logic        out_cout_hi_l;
   logic        out_cout_lo;
   logic        out_ovf_hi;
   logic        out_ovf_lo;
   logic        out_zero_hi;
   logic        out_zero_lo;
   logic [1:0]  out_in2_msb;
`ifdef EXU_ADDSUB_SPR_EN
   logic        out_spr_zero;
`endif

   sparc_exu_aluaddsub_pipe #(.WIDTH(64), .SPLIT(32), .TAG_W(6)) dut (
      .clk          (clk),
      .arst_l       (arst_l),
      .flush        (flush),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_invert    (in_invert),
      .in_cin       (in_cin),
      .in_tag       (in_tag),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_sum      (out_sum),
      .out_tag      (out_tag),
      .out_cout_hi_l(out_cout_hi_l),
      .out_cout_lo  (out_cout_lo),
      .out_ovf_hi   (out_ovf_hi),
      .out_ovf_lo   (out_ovf_lo),
      .out_zero_hi  (out_zero_hi),
      .out_zero_lo  (out_zero_lo),
      .out_in2_msb  (out_in2_msb)
`ifdef EXU_ADDSUB_SPR_EN
      ,
      .out_spr_zero (out_spr_zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] sum;
      logic [5:0]  tag;
      logic [7:0]  fl;
      logic        spr;
   } exp_t;

   exp_t       q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         n_out = 0;
   logic       acc;
   logic [7:0] obs_fl;

   assign obs_fl = {out_cout_hi_l, out_cout_lo, out_ovf_hi, out_ovf_lo,
                    out_zero_hi, out_zero_lo, out_in2_msb};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the full operands
   function automatic exp_t ref_op(input logic [63:0] a, input logic [63:0] b,
                                   input logic inv, input logic cin, input logic [5:0] tg);
      exp_t        e;
      logic [63:0] bp;
      logic [64:0] full;
      logic [32:0] lo;
      logic        oh;
      logic        ol;
      bp   = inv ? ~b : b;
      full = {1'b0, a} + {1'b0, bp} + 65'(cin);
      lo   = {1'b0, a[31:0]} + {1'b0, bp[31:0]} + 33'(cin);
      oh   = (a[63] == bp[63]) && (full[63] != a[63]);
      ol   = (a[31] == bp[31]) && (full[31] != a[31]);
      e.sum = full[63:0];
      e.tag = tg;
      e.fl  = {~full[64], lo[32], oh, ol, full[63:0] == 64'd0, full[31:0] == 32'd0, bp[63], bp[31]};
      e.spr = (full[63:0] == 64'd0);
      return e;
   endfunction

   // One clock: drive at negedge, observe 1ns later, update the in-flight queue
   task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic inv, input logic cin, input logic [5:0] tg,
                       input logic ordy, input logic fl);
      exp_t e;
      @(negedge clk);
      in_vld = v; in_rs1 = a; in_rs2 = b; in_invert = inv; in_cin = cin;
      in_tag = tg; out_rdy = ordy; flush = fl;
      #1;
      check("in_rdy", in_rdy, !fl && !(q.size() == 2 && !ordy));
      if (q.size() == 0) begin
         check("spurious_vld", out_vld, 0);
      end else if (out_vld) begin
         e = q[0];
         check("sum", out_sum, e.sum);
         check("tag", out_tag, e.tag);
         check("flags", obs_fl, e.fl);
`ifdef EXU_ADDSUB_SPR_EN
         check("spr", out_spr_zero, e.spr);
`endif
         if (ordy && !fl) begin
            void'(q.pop_front());
            n_out++;
         end
      end
      acc = v && in_rdy && !fl;
      if (fl) q.delete();
      else if (acc) q.push_back(ref_op(a, b, inv, cin, tg));
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 6'd0, ordy, 1'b0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b0;
      #2 arst_l = 1'b0;
      #1;
      check("rst_mid_vld", out_vld, 0);
      check("rst_mid_cout_hi_l", out_cout_hi_l, 1);
      check("rst_mid_sum", out_sum, 0);
      check("rst_mid_flags", obs_fl, 8'b1000_0000);
      check("rst_mid_rdy", in_rdy, 1);
      q.delete();
      @(negedge clk);
      arst_l = 1'b1;
   endtask

   task automatic directed(input logic [63:0] a, input logic [63:0] b, input logic inv,
                           input logic cin, input logic [5:0] tg, input string nm,
                           input logic [63:0] esum, input logic [7:0] efl);
      step(1'b1, a, b, inv, cin, tg, 1'b1, 1'b0);
      check({nm, "_accept"}, acc, 1);
      idle(1'b1);
      check({nm, "_lat1"}, out_vld, 0);
      idle(1'b1);
      check({nm, "_lat2"}, out_vld, 1);
      check({nm, "_sum"}, out_sum, esum);
      check({nm, "_flags"}, obs_fl, efl);
      check({nm, "_tag"}, out_tag, tg);
      idle(1'b1);
   endtask

   initial begin
      int          sent;
      int          start_out;
      int          bound;
      int          acc_cnt;
      int          cyc;
      bit          did_rst;
      logic [63:0] ta [8];
      logic [63:0] tb_ [8];
      logic [63:0] a;
      logic [63:0] b;
      logic        inv;
      logic        cin;

      arst_l = 1'b0; flush = 1'b0; in_vld = 1'b0; in_rs1 = '0; in_rs2 = '0;
      in_invert = 1'b0; in_cin = 1'b0; in_tag = '0; out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_vld", out_vld, 0);
      check("rst_sum", out_sum, 0);
      check("rst_tag", out_tag, 0);
      check("rst_flags", obs_fl, 8'b1000_0000);
      arst_l = 1'b1;

      directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 6'd1, "t1",
               64'd0, 8'b0100_1100);
      directed(64'd5, 64'd7, 1'b1, 1'b1, 6'd2, "t2",
               64'hFFFF_FFFF_FFFF_FFFE, 8'b1000_0011);
      directed(64'h7FFF_FFFF_7FFF_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 6'd3, "t3",
               64'h8000_0000_8000_0000, 8'b1011_0000);

      // Back-to-back burst with a consumer stall on cycles 3..6
      for (int i = 0; i < 8; i++) begin
         ta[i]  = {$urandom, $urandom};
         tb_[i] = {$urandom, $urandom};
      end
      sent = 0; start_out = n_out; bound = 0;
      while ((sent < 8 || q.size() != 0) && bound < 40) begin
         if (sent < 8)
            step(1'b1, ta[sent], tb_[sent], sent[0], sent[1], 6'(10 + sent),
                 !(bound >= 3 && bound <= 6), 1'b0);
         else
            idle(1'b1);
         if (acc) sent++;
         bound++;
      end
      check("t4_outputs", n_out - start_out, 8);

      // Flush with both stages full and the consumer stalled
      step(1'b1, 64'd100, 64'd1, 1'b0, 1'b0, 6'd20, 1'b0, 1'b0);
      step(1'b1, 64'd200, 64'd2, 1'b0, 1'b0, 6'd21, 1'b0, 1'b0);
      step(1'b1, 64'd300, 64'd3, 1'b0, 1'b0, 6'd22, 1'b0, 1'b0);
      check("t5_full_stall", out_vld, 1);
      step(1'b1, 64'd400, 64'd4, 1'b0, 1'b0, 6'd23, 1'b0, 1'b1);
      check("t5_flush_no_accept", acc, 0);
      idle(1'b1);
      check("t5_vld_after_flush", out_vld, 0);
      idle(1'b1);
      check("t5_vld_after_flush2", out_vld, 0);
      step(1'b1, 64'd9, 64'd4, 1'b1, 1'b1, 6'd24, 1'b1, 1'b0);
      idle(1'b1);
      check("t5_new_lat1", out_vld, 0);
      idle(1'b1);
      check("t5_new_lat2", out_vld, 1);
      check("t5_new_tag", out_tag, 24);
      check("t5_new_sum", out_sum, 5);

      // Random traffic with one mid-stream reset
      acc_cnt = 0; cyc = 0; did_rst = 0;
      while (acc_cnt < 10000 && cyc < 40000) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         cin = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: begin b = a; inv = 1'b1; cin = 1'b1; end
            1: begin b = -a; inv = 1'b0; cin = 1'b0; end
            2: begin a[31:0] = 32'hFFFF_FFFF; b[31:0] = 32'd0; end
            default: ;
         endcase
         step($urandom_range(0, 3) != 0, a, b, inv, cin, 6'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
         if (acc) acc_cnt++;
         cyc++;
         if (acc_cnt == 5000 && !did_rst) begin
            did_rst = 1;
            step(1'b1, a, b, inv, cin, 6'd60, 1'b0, 1'b0);
            step(1'b1, b, a, inv, cin, 6'd61, 1'b0, 1'b0);
            mid_reset();
         end
      end
      check("rand_ops", acc_cnt, 10000);

      bound = 0;
      while (q.size() != 0 && bound < 20) begin
         idle(1'b1);
         bound++;
      end
      check("drain", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
